// File: rtl/edf_ic_pkg.sv
// Shared types and helpers for the EDF interrupt controller.
package edf_ic_pkg;

  // Widest timestamp that slack() can handle; callers truncate to their own width.
  localparam int unsigned MaxTsWidth = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } sched_state_e;

  // Slack of a deadline relative to a time snapshot. The difference is modular, so
  // truncating the result to N bits gives slack mod 2^N, which the caller reads as signed.
  function automatic logic signed [MaxTsWidth-1:0] slack(input logic [MaxTsWidth-1:0] dl,
                                                         input logic [MaxTsWidth-1:0] now);
    return $signed(dl - now);
  endfunction

  // Width of a line index: never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edf_slack_cmp.sv
// Decides whether the line under scan replaces the current best candidate.
module edf_slack_cmp #(
  parameter int unsigned SlackWidth = 24
) (
  input  logic                  cand_valid_i,
  input  logic [SlackWidth-1:0] cand_slack_i,
  input  logic                  best_valid_i,
  input  logic [SlackWidth-1:0] best_slack_i,
  output logic                  take_o
);

  // Signed compare puts overdue lines first; strict < keeps the lower index on a tie.
  assign take_o = cand_valid_i &&
                  (!best_valid_i || ($signed(cand_slack_i) < $signed(best_slack_i)));

endmodule

// File: rtl/edf_seq_sched.sv
// Sequential earliest-deadline-first scheduler: scans one line per cycle, presents the
// least-slack enabled pending line over valid/ready, then pulses its pending-clear.
module edf_seq_sched
  import edf_ic_pkg::*;
#(
  parameter  int unsigned NrIrqs  = 4,
  parameter  int unsigned TsWidth = 24,
  localparam int unsigned IdWidth = id_width(NrIrqs)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrIrqs-1:0]         ip_i,
  input  logic [NrIrqs-1:0]         ie_i,
  input  logic [NrIrqs*TsWidth-1:0] dl_i,
  input  logic [63:0]               mtime_i,
  output logic [IdWidth-1:0]        irq_id_o,
  output logic                      irq_valid_o,
  input  logic                      irq_ready_i,
  output logic [NrIrqs-1:0]         clr_o,
  output logic                      busy_o
);

  sched_state_e       state_q, state_d;
  logic [IdWidth-1:0] idx_q, idx_d;
  logic [IdWidth-1:0] best_id_q, best_id_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               found_q, found_d;
  logic [TsWidth-1:0] best_slack_q, best_slack_d;
  logic [TsWidth-1:0] snap_q, snap_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [NrIrqs-1:0]  clr_q, clr_d;

  logic [TsWidth-1:0] dl_arr [NrIrqs];
  logic               cand_valid_c;
  logic [TsWidth-1:0] cand_slack_c;
  logic               take_c;
  logic               last_c;

  // Unpack the flat deadline bus into per-line entries.
  for (genvar k = 0; k < NrIrqs; k++) begin : g_dl
    assign dl_arr[k] = dl_i[k*TsWidth +: TsWidth];
  end

  // Only the low TsWidth bits of the timer take part in slack arithmetic.
  if (TsWidth < 64) begin : g_mtime_hi
    logic unused_mtime_hi;
    assign unused_mtime_hi = ^mtime_i[63:TsWidth];
  end

  // Candidate under scan: live pending/enable, slack against the held time snapshot.
  assign cand_valid_c = ip_i[idx_q] & ie_i[idx_q];
  assign cand_slack_c = TsWidth'(slack(MaxTsWidth'(dl_arr[idx_q]), MaxTsWidth'(snap_q)));
  assign last_c       = (idx_q == IdWidth'(NrIrqs - 1));

  edf_slack_cmp #(
    .SlackWidth (TsWidth)
  ) u_cmp (
    .cand_valid_i (cand_valid_c),
    .cand_slack_i (cand_slack_c),
    .best_valid_i (found_q),
    .best_slack_i (best_slack_q),
    .take_o       (take_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_id_d    = best_id_q;
    id_d         = id_q;
    found_d      = found_q;
    best_slack_d = best_slack_q;
    snap_d       = snap_q;
    clr_d        = '0;

    case (state_q)
      IDLE: begin
        idx_d   = '0;
        found_d = 1'b0;
        snap_d  = mtime_i[TsWidth-1:0];
        if (|(ip_i & ie_i)) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (take_c) begin
          best_slack_d = cand_slack_c;
          best_id_d    = idx_q;
          found_d      = 1'b1;
        end
        if (last_c) begin
          state_d = (found_q || take_c) ? PRESENT : IDLE;
          id_d    = take_c ? idx_q : best_id_q;
        end else begin
          idx_d = idx_q + IdWidth'(1);
        end
      end
      PRESENT: begin
        if (irq_ready_i) begin
          state_d = CLEAR;
          clr_d   = NrIrqs'(1) << best_id_q;
        end else if (!(ip_i[best_id_q] & ie_i[best_id_q])) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      best_id_q    <= '0;
      id_q         <= '0;
      found_q      <= 1'b0;
      best_slack_q <= '0;
      snap_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      clr_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_id_q    <= best_id_d;
      id_q         <= id_d;
      found_q      <= found_d;
      best_slack_q <= best_slack_d;
      snap_q       <= snap_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      clr_q        <= clr_d;
    end
  end

  assign irq_id_o    = id_q;
  assign irq_valid_o = valid_q;
  assign clr_o       = clr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_edf_seq_sched.sv
// Scoreboard bench for edf_seq_sched: stimulus pushes expected winners, a monitor pops
// and compares on each new presentation and checks every pending-clear pulse.
module tb_edf_seq_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         ip  = '0;
  logic [N-1:0]         ie  = '0;
  logic [N-1:0][TW-1:0] dl  = '0;
  logic [63:0]          mtime = '0;
  logic                 rdy = 1'b0;
  logic                 ready_en = 1'b1;

  logic [1:0]           irq_id_o;
  logic                 irq_valid_o;
  logic [N-1:0]         clr_o;
  logic                 busy_o;

  int n_checks = 0;
  int n_err    = 0;
  int exp_q[$];

  edf_seq_sched #(.NrIrqs(N), .TsWidth(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ip_i        (ip),
    .ie_i        (ie),
    .dl_i        (dl),
    .mtime_i     (mtime),
    .irq_id_o    (irq_id_o),
    .irq_valid_o (irq_valid_o),
    .irq_ready_i (rdy),
    .clr_o       (clr_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: least signed slack (mod 2^TW) among enabled pending lines, lowest index on tie.
  function automatic int model();
    int best = -1;
    int bs   = 0;
    for (int k = 0; k < N; k++) begin
      if (ip[k] && ie[k]) begin
        logic [TW-1:0] d;
        int s;
        d = dl[k] - mtime[TW-1:0];
        s = int'(d);
        if (d[TW-1]) s = s - (1 << TW);
        if (best < 0 || s < bs) begin
          best = k;
          bs   = s;
        end
      end
    end
    return best;
  endfunction

  // Random ready, changed just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rdy = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: pops an expected id on each new presentation, checks id stability and clr pulses.
  initial begin
    logic [N-1:0] pend_clr = '0;
    bit           prev_v   = 1'b0;
    int           cur      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_clr = '0;
        prev_v   = 1'b0;
      end else begin
        check("clr", clr_o, pend_clr);
        pend_clr = '0;
        if (irq_valid_o) begin
          if (!prev_v) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL present: unexpected id %0d, nothing expected", irq_id_o);
              cur = irq_id_o;
            end else begin
              cur = exp_q.pop_front();
              check("id", irq_id_o, cur);
            end
          end else begin
            check("id_stable", irq_id_o, cur);
          end
          if (rdy) pend_clr = N'(1) << cur;
        end
        prev_v = irq_valid_o;
      end
    end
  end

  task automatic wait_valid(input int lat, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (irq_valid_o) seen = 1'b1;
    end
    check({name, "_latency"}, seen ? n : -1, lat);
  endtask

  // Wait for the clear pulse of an accepted winner, then drop its pending bit.
  task automatic finish_one(input int e);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (clr_o != '0) seen = 1'b1;
    end
    check("clr_seen", seen, 1);
    ip[e] = 1'b0;
  endtask

  // Serve every pending line until none is left; re-presents come after CLEAR, IDLE, scan.
  task automatic serve(input int first_lat);
    int lat = first_lat;
    int e;
    forever begin
      e = model();
      if (e < 0) break;
      exp_q.push_back(e);
      wait_valid(lat, "serve");
      finish_one(e);
      lat = 6;
    end
  endtask

  task automatic go_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy_o, 0);
    ready_en = 1'b1;
  endtask

  task automatic apply(input logic [N-1:0] ip_v, input logic [N-1:0] ie_v,
                       input logic [63:0] mt, input logic [N-1:0][TW-1:0] dl_v);
    ip    = ip_v;
    ie    = ie_v;
    mtime = mt;
    dl    = dl_v;
  endtask

  initial begin
    int e;
    int e2;
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int e2;
    repeat (3) @(negedge clk);
    check("rst_valid", irq_valid_o, 0);
    check("rst_id", irq_id_o, 0);
    check("rst_clr", clr_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single line pending, one-cycle clear, then quiet.
    go_idle();
    apply(4'b0100, 4'b1111, 64'h80, {24'h0, 24'h000100, 24'h0, 24'h0});
    serve(5);
    @(negedge clk);
    check("s1_valid_after", irq_valid_o, 0);
    check("s1_busy_after", busy_o, 0);

    // Four lines, served in deadline order with rescans.
    go_idle();
    apply(4'b1111, 4'b1111, 64'h0, {24'h400, 24'h200, 24'h100, 24'h300});
    serve(5);

    // Timer wrap: slack is modular and signed.
    go_idle();
    apply(4'b0011, 4'b1111, 64'h1234_5678_00FF_FFF0, {24'h0, 24'h0, 24'hFFFFF8, 24'h000010});
    serve(5);
    go_idle();
    apply(4'b0111, 4'b1111, 64'h1234_5678_00FF_FFF0, {24'h0, 24'hFFFFE0, 24'hFFFFF8, 24'h000010});
    serve(5);

    // Tie resolved to lower index; disabled line skipped.
    go_idle();
    apply(4'b1010, 4'b1111, 64'h0, {24'h500, 24'h0, 24'h500, 24'h0});
    serve(5);
    go_idle();
    apply(4'b1010, 4'b1101, 64'h0, {24'h500, 24'h0, 24'h500, 24'h0});
    serve(5);
    ie = 4'b1111;
    ip = 4'b0000;

    // Retract: winner's pending drops while not ready, no clear, remaining line rescanned.
    go_idle();
    ready_en = 1'b0;
    apply(4'b0011, 4'b1111, 64'h1000, {24'h0, 24'h0, 24'h1100, 24'h1010});
    e = model();
    exp_q.push_back(e);
    wait_valid(5, "retract");
    @(negedge clk);
    @(negedge clk);
    ip[e] = 1'b0;
    e2 = model();
    @(negedge clk);
    check("retract_valid", irq_valid_o, 0);
    check("retract_busy", busy_o, 0);
    ready_en = 1'b1;
    exp_q.push_back(e2);
    wait_valid(5, "rescan");
    finish_one(e2);
    serve(6);

    // Reset in the second scan cycle drops everything; scan restarts after release.
    go_idle();
    apply(4'b1111, 4'b1111, 64'h0, {24'h400, 24'h200, 24'h100, 24'h300});
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", irq_valid_o, 0);
    check("midrst_id", irq_id_o, 0);
    check("midrst_clr", clr_o, 0);
    check("midrst_busy", busy_o, 0);
    #1 rst = 1'b0;
    e = model();
    exp_q.push_back(e);
    wait_valid(5, "after_reset");
    finish_one(e);
    serve(6);

    // Randomized traffic, deadlines often clustered around the timer to force ties and wraps.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0][TW-1:0] dv;
      logic [63:0] mt;
      mt = {32'($urandom), 32'($urandom)};
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 2))
          0:       dv[k] = TW'($urandom);
          1:       dv[k] = mt[TW-1:0] + TW'($urandom_range(0, 63)) - TW'(32);
          default: dv[k] = (k > 0) ? dv[k-1] : mt[TW-1:0];
        endcase
      end
      go_idle();
      apply(N'($urandom), N'($urandom), mt, dv);
      e = model();
      if (e < 0) begin
        repeat (6) @(negedge clk);
        check("rand_no_cand_busy", busy_o, 0);
      end else begin
        serve(5);
      end
    end

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
